// File: rtl/snake_ps2_direction.sv
// PS/2 device-to-host receiver with arrow/WASD decoding into a held one-hot
// direction for the snake game top level.
module snake_ps2_direction #(
   parameter int unsigned CLK_FREQ      = 106470000,
   parameter int unsigned TIMEOUT_US    = 1000,
   parameter logic [3:0]  INIT_DIR      = 4'b0001,
   parameter bit          ALLOW_REVERSE = 1'b0
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_PS2Clk,
   input  logic       i_PS2Data,
   output logic [3:0] o_Direction,
   output logic       o_DirValid,
   output logic [7:0] o_ScanCode,
   output logic       o_ScanValid,
   output logic       o_FrameErr
);

   localparam int unsigned TIMEOUT_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
   localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t          r_State, w_NextState;
   logic [1:0]      r_ClkSync, r_DataSync;
   logic            r_ClkPrev, r_Strobe, r_SData;
   logic [2:0]      r_BitCnt, w_NextBitCnt;
   logic [7:0]      r_Shift, w_NextShift;
   logic            r_Parity, w_NextParity;
   logic [TW-1:0]   r_Timer, w_NextTimer;
   logic            w_ScanLoad, w_FrameErr;
   logic [7:0]      r_ScanCode;
   logic            r_ScanValid, r_FrameErr;
   logic            r_Ext, r_Brk;
   logic [3:0]      r_Dir;
   logic            r_DirValid;
   logic [3:0]      w_MapDir, w_Opposite;
   logic            w_Mapped, w_Accept;

   // Strobe is registered so the paired data sample is the synchronised value
   // present at the falling edge.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_ClkSync  <= '1;
         r_DataSync <= '1;
         r_ClkPrev  <= 1'b1;
         r_Strobe   <= 1'b0;
         r_SData    <= 1'b1;
      end else begin
         r_ClkSync  <= {r_ClkSync[0], i_PS2Clk};
         r_DataSync <= {r_DataSync[0], i_PS2Data};
         r_ClkPrev  <= r_ClkSync[1];
         r_Strobe   <= r_ClkPrev & ~r_ClkSync[1];
         r_SData    <= r_DataSync[1];
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_State     <= S_IDLE;
         r_BitCnt    <= '0;
         r_Shift     <= '0;
         r_Parity    <= 1'b0;
         r_Timer     <= '0;
         r_ScanCode  <= '0;
         r_ScanValid <= 1'b0;
         r_FrameErr  <= 1'b0;
      end else begin
         r_State     <= w_NextState;
         r_BitCnt    <= w_NextBitCnt;
         r_Shift     <= w_NextShift;
         r_Parity    <= w_NextParity;
         r_Timer     <= w_NextTimer;
         r_ScanValid <= w_ScanLoad;
         r_FrameErr  <= w_FrameErr;
         if (w_ScanLoad) r_ScanCode <= r_Shift;
      end
   end

   always_comb begin
      w_NextState  = r_State;
      w_NextBitCnt = r_BitCnt;
      w_NextShift  = r_Shift;
      w_NextParity = r_Parity;
      w_NextTimer  = '0;
      w_ScanLoad   = 1'b0;
      w_FrameErr   = 1'b0;
      if (r_State != S_IDLE && !r_Strobe) begin
         if (r_Timer == TW'(TIMEOUT_CYC - 1)) begin
            w_FrameErr  = 1'b1;
            w_NextState = S_IDLE;
         end else begin
            w_NextTimer = r_Timer + 1'b1;
         end
      end
      if (r_Strobe) begin
         case (r_State)
            S_IDLE: begin
               if (!r_SData) begin
                  w_NextState  = S_DATA;
                  w_NextBitCnt = '0;
               end
            end
            S_DATA: begin
               w_NextShift  = {r_SData, r_Shift[7:1]};
               w_NextBitCnt = r_BitCnt + 1'b1;
               if (r_BitCnt == 3'd7) w_NextState = S_PARITY;
            end
            S_PARITY: begin
               w_NextParity = r_SData;
               w_NextState  = S_STOP;
            end
            S_STOP: begin
               if (r_SData && (^{r_Shift, r_Parity})) w_ScanLoad = 1'b1;
               else                                   w_FrameErr = 1'b1;
               w_NextState = S_IDLE;
            end
            default: w_NextState = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_MapDir = '0;
      w_Mapped = 1'b0;
      case ({r_Ext, r_ScanCode})
         {1'b1, 8'h75}: begin w_MapDir = 4'b1000; w_Mapped = 1'b1; end
         {1'b1, 8'h72}: begin w_MapDir = 4'b0100; w_Mapped = 1'b1; end
         {1'b1, 8'h6B}: begin w_MapDir = 4'b0010; w_Mapped = 1'b1; end
         {1'b1, 8'h74}: begin w_MapDir = 4'b0001; w_Mapped = 1'b1; end
         {1'b0, 8'h1D}: begin w_MapDir = 4'b1000; w_Mapped = 1'b1; end
         {1'b0, 8'h1B}: begin w_MapDir = 4'b0100; w_Mapped = 1'b1; end
         {1'b0, 8'h1C}: begin w_MapDir = 4'b0010; w_Mapped = 1'b1; end
         {1'b0, 8'h23}: begin w_MapDir = 4'b0001; w_Mapped = 1'b1; end
         default: ;
      endcase
      w_Opposite = {r_Dir[2], r_Dir[3], r_Dir[0], r_Dir[1]};
      w_Accept   = !r_Brk && w_Mapped && (w_MapDir != r_Dir) &&
                   (ALLOW_REVERSE || (w_MapDir != w_Opposite));
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_Ext      <= 1'b0;
         r_Brk      <= 1'b0;
         r_Dir      <= INIT_DIR;
         r_DirValid <= 1'b0;
      end else begin
         r_DirValid <= 1'b0;
         if (r_ScanValid) begin
            if (r_ScanCode == 8'hE0) begin
               r_Ext <= 1'b1;
            end else if (r_ScanCode == 8'hF0) begin
               r_Brk <= 1'b1;
            end else begin
               r_Ext <= 1'b0;
               r_Brk <= 1'b0;
               if (w_Accept) begin
                  r_Dir      <= w_MapDir;
                  r_DirValid <= 1'b1;
               end
            end
         end
      end
   end

   assign o_Direction = r_Dir;
   assign o_DirValid  = r_DirValid;
   assign o_ScanCode  = r_ScanCode;
   assign o_ScanValid = r_ScanValid;
   assign o_FrameErr  = r_FrameErr;

endmodule

// File: tb/tb_snake_ps2_direction.sv
// Directed bench for snake_ps2_direction; a second instance with reversal
// allowed shares the same PS/2 stimulus.
module tb_snake_ps2_direction;

   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2clk = 1'b1;
   logic       ps2data = 1'b1;
   logic [3:0] dir0, dir1;
   logic       dv0, dv1, sv0, sv1, fe0, fe1;
   logic [7:0] code0, code1;

   int checks = 0;
   int errors = 0;
   int sv_cnt = 0, dv_cnt = 0, fe_cnt = 0, wide_cnt = 0;
   logic [7:0] sv_codes [0:7];
   logic p_sv = 1'b0, p_dv = 1'b0, p_fe = 1'b0;

   snake_ps2_direction #(.CLK_FREQ(10000000), .TIMEOUT_US(100),
                         .INIT_DIR(4'b0001), .ALLOW_REVERSE(1'b0)) dut0 (
      .i_Clk(clk), .i_Rst(rst), .i_PS2Clk(ps2clk), .i_PS2Data(ps2data),
      .o_Direction(dir0), .o_DirValid(dv0), .o_ScanCode(code0),
      .o_ScanValid(sv0), .o_FrameErr(fe0));

   snake_ps2_direction #(.CLK_FREQ(10000000), .TIMEOUT_US(100),
                         .INIT_DIR(4'b0001), .ALLOW_REVERSE(1'b1)) dut1 (
      .i_Clk(clk), .i_Rst(rst), .i_PS2Clk(ps2clk), .i_PS2Data(ps2data),
      .o_Direction(dir1), .o_DirValid(dv1), .o_ScanCode(code1),
      .o_ScanValid(sv1), .o_FrameErr(fe1));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sv0) begin
         if (sv_cnt < 8) sv_codes[sv_cnt] = code0;
         sv_cnt = sv_cnt + 1;
      end
      if (dv0) dv_cnt = dv_cnt + 1;
      if (fe0) fe_cnt = fe_cnt + 1;
      if ((sv0 && p_sv) || (dv0 && p_dv) || (fe0 && p_fe)) wide_cnt = wide_cnt + 1;
      p_sv = sv0; p_dv = dv0; p_fe = fe0;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic clear_counts();
      @(posedge clk);
      sv_cnt = 0; dv_cnt = 0; fe_cnt = 0;
   endtask

   task automatic send_bit(input logic b);
      ps2data = b;
      wait_cyc(HALF);
      ps2clk = 1'b0;
      wait_cyc(HALF);
      ps2clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_par, input int gap);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(bad_par ? (^d) : ~(^d));
      send_bit(1'b1);
      wait_cyc(gap);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      wait_cyc(3);
      @(negedge clk);
      rst = 1'b0;
      wait_cyc(2);
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if (dir0 !== 4'b0001) begin errors++; $display("FAIL reset_dir: got %b expected 0001", dir0); end
      checks++; if (code0 !== 8'h00) begin errors++; $display("FAIL reset_code: got %h expected 00", code0); end
      checks++; if ({sv0, dv0, fe0} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {sv0, dv0, fe0}); end
   endtask

   task automatic test_up_arrow();
      clear_counts();
      send_frame(8'hE0, 1'b0, 20);
      send_frame(8'h75, 1'b0, 20);
      @(negedge clk);
      checks++; if (sv_cnt !== 2) begin errors++; $display("FAIL up_sv_count: got %0d expected 2", sv_cnt); end
      checks++; if (sv_codes[0] !== 8'hE0) begin errors++; $display("FAIL up_code0: got %h expected E0", sv_codes[0]); end
      checks++; if (sv_codes[1] !== 8'h75) begin errors++; $display("FAIL up_code1: got %h expected 75", sv_codes[1]); end
      checks++; if (dir0 !== 4'b1000) begin errors++; $display("FAIL up_dir: got %b expected 1000", dir0); end
      checks++; if (dv_cnt !== 1) begin errors++; $display("FAIL up_dv_count: got %0d expected 1", dv_cnt); end
   endtask

   task automatic test_reversal();
      do_reset();
      clear_counts();
      send_frame(8'hE0, 1'b0, 20);
      send_frame(8'h6B, 1'b0, 20);
      @(negedge clk);
      checks++; if (dir0 !== 4'b0001) begin errors++; $display("FAIL rev_dir_blocked: got %b expected 0001", dir0); end
      checks++; if (dv_cnt !== 0) begin errors++; $display("FAIL rev_dv_count: got %0d expected 0", dv_cnt); end
      checks++; if (dir1 !== 4'b0010) begin errors++; $display("FAIL rev_dir_allowed: got %b expected 0010", dir1); end
   endtask

   task automatic test_bad_parity();
      clear_counts();
      send_frame(8'h1D, 1'b1, 20);
      @(negedge clk);
      checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL par_fe_count: got %0d expected 1", fe_cnt); end
      checks++; if (sv_cnt !== 0) begin errors++; $display("FAIL par_sv_count: got %0d expected 0", sv_cnt); end
      checks++; if (dir0 !== 4'b0001) begin errors++; $display("FAIL par_dir: got %b expected 0001", dir0); end
   endtask

   task automatic test_break_make();
      send_frame(8'hE0, 1'b0, 20);
      send_frame(8'h75, 1'b0, 20);
      @(negedge clk);
      checks++; if (dir0 !== 4'b1000) begin errors++; $display("FAIL brk_setup_dir: got %b expected 1000", dir0); end
      clear_counts();
      send_frame(8'hE0, 1'b0, 20);
      send_frame(8'hF0, 1'b0, 20);
      send_frame(8'h75, 1'b0, 20);
      @(negedge clk);
      checks++; if (sv_cnt !== 3) begin errors++; $display("FAIL brk_sv_count: got %0d expected 3", sv_cnt); end
      checks++; if (dir0 !== 4'b1000 || dv_cnt !== 0) begin errors++; $display("FAIL brk_no_change: got dir %b dv %0d expected 1000 0", dir0, dv_cnt); end
      clear_counts();
      send_frame(8'h1C, 1'b0, 20);
      @(negedge clk);
      checks++; if (dir0 !== 4'b0010) begin errors++; $display("FAIL brk_left_dir: got %b expected 0010", dir0); end
      checks++; if (dv_cnt !== 1) begin errors++; $display("FAIL brk_left_dv: got %0d expected 1", dv_cnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      clear_counts();
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      ps2data = 1'b1;
      wait_cyc(1500);
      @(negedge clk);
      checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL to_fe_count: got %0d expected 1", fe_cnt); end
      clear_counts();
      send_frame(8'h23, 1'b0, 20);
      @(negedge clk);
      checks++; if (code0 !== 8'h23 || sv_cnt !== 1) begin errors++; $display("FAIL to_code: got %h x%0d expected 23 x1", code0, sv_cnt); end
      checks++; if (dir0 !== 4'b0001 || dv_cnt !== 0) begin errors++; $display("FAIL to_dir: got %b dv %0d expected 0001 0", dir0, dv_cnt); end
      checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL to_recover_fe: got %0d expected 0", fe_cnt); end
   endtask

   task automatic test_reset_mid();
      send_frame(8'h1D, 1'b0, 20);
      @(negedge clk);
      checks++; if (dir0 !== 4'b1000) begin errors++; $display("FAIL mid_setup_dir: got %b expected 1000", dir0); end
      send_bit(1'b0);
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++; if (dir0 !== 4'b0001 || code0 !== 8'h00) begin errors++; $display("FAIL mid_async_reset: got dir %b code %h expected 0001 00", dir0, code0); end
      checks++; if ({sv0, dv0, fe0} !== 3'b000) begin errors++; $display("FAIL mid_async_pulses: got %b expected 000", {sv0, dv0, fe0}); end
      ps2data = 1'b1;
      wait_cyc(3);
      @(negedge clk);
      rst = 1'b0;
      clear_counts();
      send_frame(8'hE0, 1'b0, 20);
      send_frame(8'h72, 1'b0, 20);
      @(negedge clk);
      checks++; if (dir0 !== 4'b0100 || dv_cnt !== 1) begin errors++; $display("FAIL mid_down_dir: got %b dv %0d expected 0100 1", dir0, dv_cnt); end
      checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL mid_fe: got %0d expected 0", fe_cnt); end
   endtask

   task automatic test_back_to_back();
      clear_counts();
      send_frame(8'h1C, 1'b0, 0);
      send_frame(8'h1D, 1'b0, 20);
      @(negedge clk);
      checks++; if (sv_cnt !== 2 || fe_cnt !== 0) begin errors++; $display("FAIL b2b_counts: got sv %0d fe %0d expected 2 0", sv_cnt, fe_cnt); end
      checks++; if (dir0 !== 4'b1000 || dv_cnt !== 2) begin errors++; $display("FAIL b2b_dir: got %b dv %0d expected 1000 2", dir0, dv_cnt); end
      checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL pulse_width: got %0d wide pulses expected 0", wide_cnt); end
   endtask

   initial begin
      test_reset();
      test_up_arrow();
      test_reversal();
      test_bad_parity();
      test_break_make();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/snake_ps2_direction.md
# snake_ps2_direction

PS/2 keyboard receiver and key decoder that drives the 4-bit direction input of the snake game top level. It deserialises PS/2 device-to-host frames and checks framing, parity and inter-bit timeout. It then decodes arrow keys (extended set-2 codes) and WASD make codes into a held one-hot direction, with optional reversal rejection. It sits between the board PS/2 pins and `snake_device.i_Direction`, in the system clock domain.

## Interface
- `CLK_FREQ`, 106470000: system clock frequency in Hz.
- `TIMEOUT_US`, 1000: maximum gap between PS/2 falling edges inside a frame, in µs.
  - Timeout cycle count is `CLK_FREQ/1000000*TIMEOUT_US`.
- `INIT_DIR`, 4'b0001: direction value after reset (right).
- `ALLOW_REVERSE`, 0: when 0, a direction opposite the current one is ignored.

- `i_Clk`, input, 1: system clock; all logic is on its rising edge.
- `i_Rst`, input, 1: asynchronous, active-high reset.
- `i_PS2Clk`, input, 1: raw PS/2 clock pin, asynchronous.
- `i_PS2Data`, input, 1: raw PS/2 data pin, asynchronous.
- `o_Direction`, output, 4: held one-hot direction, bit3 up, bit2 down, bit1 left, bit0 right.
- `o_DirValid`, output, 1: one-cycle pulse when `o_Direction` changes value.
- `o_ScanCode`, output, 8: last correctly received byte.
- `o_ScanValid`, output, 1: one-cycle pulse when `o_ScanCode` is loaded.
- `o_FrameErr`, output, 1: one-cycle pulse when a frame is discarded.

## Operation
- **Reset values:**
  - `o_Direction = INIT_DIR`.
  - `o_ScanCode = 8'h00`.
  - All pulses 0.
  - Receiver FSM in IDLE; ext/brk flags cleared; synchronisers set to 1 (bus idle high).
- **Input conditioning:**
  - Both pins pass through 2-FF synchronisers.
  - A falling edge is registered `sync_prev=1 && sync=0` on the PS/2 clock; this is the sample strobe.
- **Receiver FSM (IDLE, DATA, PARITY, STOP):**
  - IDLE:
    - Strobe with data=0 → DATA, bit counter=0.
    - Strobe with data=1 → stay in IDLE, no error.
  - DATA: shift data LSB first on each strobe; after the 8th bit → PARITY.
  - PARITY: record the bit; → STOP.
  - STOP, on strobe:
    - If stop=1 and (8 data bits + parity) has odd weight → pulse `o_ScanValid`, load `o_ScanCode`.
    - Otherwise → pulse `o_FrameErr`.
    - Either way → IDLE.
  - Timeout: in any non-IDLE state, the counter reaches the timeout count with no strobe → `o_FrameErr` pulse, → IDLE. The counter is cleared on every strobe and in IDLE.
- **Key decoder** (acts on each `o_ScanValid` byte, one cycle later):
  - `E0`: set ext.
  - `F0`: set brk.
  - Any other byte:
    - If brk=1 → no action (key release).
    - Else if ext=1, map `75`→up, `72`→down, `6B`→left, `74`→right.
    - Else if ext=0, map `1D`→up, `1B`→down, `1C`→left, `23`→right.
    - Clear both flags.
  - Unmapped codes clear the flags only.
  - Mapped make: if `ALLOW_REVERSE=0` and the new direction equals the bitwise opposite (up↔down, left↔right) of `o_Direction` → ignore.
  - Equal to current direction → no update, no pulse.
  - Otherwise load `o_Direction` and pulse `o_DirValid`.
- `o_FrameErr` does not alter the ext/brk flags.
- `o_Direction` is always exactly one-hot.

## Timing
- Pin falling edge to strobe: 3 cycles (2 sync stages + edge register).
- Stop-bit strobe to `o_ScanValid`: 1 cycle.
- `o_ScanValid` to `o_DirValid`/`o_Direction` update: 1 cycle.
- Pulses are exactly one cycle wide and never back-to-back from the same frame.
- The receiver accepts a new start bit on the strobe immediately following STOP.
- Asynchronous reset mid-frame:
  - All outputs take reset values immediately, with no clock needed.
  - The partial frame is discarded.
  - After release, reception restarts at the next start bit.
- Assumes PS/2 clock ≤ 16.7 kHz ≪ `CLK_FREQ`; no minimum `CLK_FREQ` check in RTL.

## Test plan
- **Up arrow:** reset, send frames `E0`, `75` with correct parity.
  - Expect two `o_ScanValid` pulses with codes `E0` then `75`.
  - Expect `o_Direction=4'b1000` and one `o_DirValid` pulse.
- **Reversal rejection:** reset (`o_Direction=0001`), send `E0 6B`.
  - With `ALLOW_REVERSE=0`: `o_Direction` stays `0001`, no `o_DirValid`.
  - With `ALLOW_REVERSE=1`: `o_Direction` becomes `0010`.
- **Bad parity:** send `1D` with even parity.
  - Expect one `o_FrameErr` pulse, no `o_ScanValid`, direction unchanged.
- **Break then make:** after up, send `E0 F0 75`.
  - Expect three `o_ScanValid` pulses and no direction change.
  - Then send `1C`: `o_Direction=0010`, one `o_DirValid`.
- **Timeout recovery:** send start plus 4 data bits, then hold the clock high longer than `TIMEOUT_US`.
  - Expect one `o_FrameErr` pulse.
  - Then a full `23` frame gives `o_ScanCode=23` and `o_Direction=0001` (unchanged, no pulse).
- **Reset mid-frame:** assert `i_Rst` after 5 bits of frame `E0`, asynchronous to `i_Clk`.
  - All outputs return to reset values within the same cycle.
  - After release, `E0 72` yields `o_Direction=0100`, provided `INIT_DIR` is not `1000`.
